// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame constants and baud divider helper
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  function automatic int bps_cnt(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser with falling-edge detect for an async line idling high
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic rxd_d0;
  logic rxd_d1;
  logic rxd_d2;

  // Reset to the idle level so release never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_d0 <= 1'b1;
      rxd_d1 <= 1'b1;
      rxd_d2 <= 1'b1;
    end else begin
      rxd_d0 <= rxd;
      rxd_d1 <= rxd_d0;
      rxd_d2 <= rxd_d1;
    end
  end

  assign rxd_s = rxd_d1;
  assign fall  = rxd_d2 & ~rxd_d1;

endmodule

// File: rtl/uart_recv.sv
// rtl/uart_recv.sv - 8N1 UART receiver producing a byte with a one-cycle done or framing-error strobe
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err
);

  localparam int          BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [15:0] MID_CNT = 16'(BPS_CNT / 2);
  localparam logic [15:0] END_CNT = 16'(BPS_CNT - 1);
  localparam logic [3:0]  END_BIT = 4'(DATA_BITS - 1);

  logic                 rxd_s;
  logic                 fall;
  uart_state_t          state;
  uart_state_t          state_nxt;
  logic [15:0]          clk_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 mid;
  logic                 wrap;

  uart_rx_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rxd       (uart_rxd),
    .rxd_s     (rxd_s),
    .fall      (fall)
  );

  assign mid  = (clk_cnt == MID_CNT);
  assign wrap = (clk_cnt == END_CNT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Leaving STOP at mid-bit gives half a bit of slack to catch a back-to-back start edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: begin
        if (mid && rxd_s)  state_nxt = IDLE;
        else if (wrap)     state_nxt = DATA;
      end
      DATA:  if (wrap && bit_cnt == END_BIT) state_nxt = STOP;
      STOP:  if (mid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_cnt   <= 16'd0;
      bit_cnt   <= 4'd0;
      rx_shift  <= '0;
      uart_data <= 8'd0;
      uart_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      uart_done <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE || state_nxt == IDLE || wrap) clk_cnt <= 16'd0;
      else                                            clk_cnt <= clk_cnt + 16'd1;

      if (state == START && wrap)                          bit_cnt <= 4'd0;
      else if (state == DATA && wrap && bit_cnt != END_BIT) bit_cnt <= bit_cnt + 4'd1;

      if (state == DATA && mid) rx_shift[bit_cnt[2:0]] <= rxd_s;

      // A low stop bit keeps the previous byte visible and only flags the error.
      if (state == STOP && mid) begin
        if (rxd_s == STOP_LEVEL) begin
          uart_data <= rx_shift;
          uart_done <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// tb/tb_uart_recv.sv - scoreboard bench for uart_recv with directed 8N1 frames
module tb_uart_recv;

  localparam int BPS = 10;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       uart_rxd;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       frame_err;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_done = -1000;
  int   prev_done = -1000;
  int   start_cyc;
  bit   prev_evt = 1'b0;
  exp_t exp_q[$];

  uart_recv #(
    .CLK_FREQ (1000000),
    .UART_BPS (100000)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .uart_data (uart_data),
    .uart_done (uart_done),
    .frame_err (frame_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every strobe pops one expectation.
  always @(negedge sys_clk) begin
    if (uart_done || frame_err) begin
      exp_t e;
      chk("strobe_exclusive", {31'd0, uart_done & frame_err}, 32'd0);
      chk("strobe_not_consecutive", {31'd0, prev_evt}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual=done%0b/err%0b data=0x%02h required=no strobe",
                 uart_done, frame_err, uart_data);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind_is_err", {31'd0, frame_err}, {31'd0, e.err});
        chk("strobe_data", {24'd0, uart_data}, {24'd0, e.data});
      end
      if (uart_done) begin
        prev_done = last_done;
        last_done = cyc;
      end
    end
    prev_evt = uart_done | frame_err;
  end

  task automatic expect_byte(input logic [7:0] b);
    exp_t e;
    e.err  = 1'b0;
    e.data = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [7:0] held);
    exp_t e;
    e.err  = 1'b1;
    e.data = held;
    exp_q.push_back(e);
  endtask

  // Called on a negedge; returns on the negedge after the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    uart_rxd  = 1'b0;
    repeat (BPS) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BPS) @(negedge sys_clk);
    end
    uart_rxd = stop;
    repeat (BPS) @(negedge sys_clk);
    uart_rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    int d;
    logic [7:0] c6;
    c6        = 8'hC6;
    uart_rxd  = 1'b1;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("reset_data", {24'd0, uart_data}, 32'd0);
    chk("reset_done", {31'd0, uart_done}, 32'd0);
    chk("reset_err", {31'd0, frame_err}, 32'd0);
    sys_rst_n = 1'b1;

    idle(500);
    chk("idle_data", {24'd0, uart_data}, 32'd0);

    expect_byte(8'h55);
    send_byte(8'h55, 1'b1);
    idle(20);
    d = last_done - start_cyc;
    checks++;
    if (d < 97 || d > 99) begin
      errors++;
      $display("FAIL latency_55 actual=%0d required=98+-1", d);
    end

    expect_byte(8'hA3);
    expect_byte(8'h0F);
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    idle(20);
    chk("gap_a3_0f", last_done - prev_done, 32'd100);

    uart_rxd = 1'b0;
    repeat (3) @(negedge sys_clk);
    idle(30);
    chk("glitch_data_kept", {24'd0, uart_data}, 32'h0F);
    expect_byte(8'h3C);
    send_byte(8'h3C, 1'b1);
    idle(20);

    expect_byte(8'h12);
    send_byte(8'h12, 1'b1);
    expect_err(8'h12);
    send_byte(8'hFF, 1'b0);
    idle(30);
    chk("ferr_data_held", {24'd0, uart_data}, 32'h12);

    uart_rxd = 1'b0;
    repeat (BPS) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = c6[i];
      repeat (BPS) @(negedge sys_clk);
    end
    uart_rxd = c6[4];
    repeat (BPS / 2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("midframe_reset_data", {24'd0, uart_data}, 32'd0);
    sys_rst_n = 1'b1;
    idle(150);
    chk("after_reset_data", {24'd0, uart_data}, 32'd0);

    expect_byte(8'h81);
    send_byte(8'h81, 1'b1);
    idle(20);
    chk("final_data", {24'd0, uart_data}, 32'h81);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
